// File: rtl/wii_nunchuk_reader.sv
// rtl/wii_nunchuk_reader.sv - I2C initiator that initialises and polls a Wii Nunchuk into a 48-bit sample word
module wii_nunchuk_reader #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned I2C_HZ    = 100_000,
    parameter logic [6:0]  DEV_ADDR  = 7'h52,
    parameter int unsigned CONV_CYC  = 100_000,
    parameter int unsigned POLL_CYC  = 1_000_000,
    parameter int unsigned RETRY_CYC = 10_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic [47:0] wii_data,
    output logic        data_valid,
    output logic        busy,
    output logic        ack_error
);
    localparam int unsigned QTR = CLK_HZ / (4 * I2C_HZ);
    localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

    // Bit-level transaction states
    localparam logic [2:0] T_IDLE   = 3'd0;
    localparam logic [2:0] T_START  = 3'd1;
    localparam logic [2:0] T_TXBYTE = 3'd2;
    localparam logic [2:0] T_RXACK  = 3'd3;
    localparam logic [2:0] T_RXBYTE = 3'd4;
    localparam logic [2:0] T_TXACK  = 3'd5;
    localparam logic [2:0] T_STOP   = 3'd6;

    // Sequencer states; the *W states are pure delays with the bus idle
    localparam logic [2:0] Q_INIT1  = 3'd0;
    localparam logic [2:0] Q_INIT2  = 3'd1;
    localparam logic [2:0] Q_CONV   = 3'd2;
    localparam logic [2:0] Q_CONVW  = 3'd3;
    localparam logic [2:0] Q_READ   = 3'd4;
    localparam logic [2:0] Q_POLLW  = 3'd5;
    localparam logic [2:0] Q_RETRYW = 3'd6;

    logic [1:0]    sda_sync;
    logic          sda_s;
    logic [2:0]    tstate;
    logic [2:0]    sstate;
    logic [1:0]    phase;
    logic [QW-1:0] qcnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic [7:0]    tx_sh;
    logic [47:0]   rx_buf;
    logic          nack_seen;
    logic          issued;
    logic [31:0]   wcnt;
    logic [31:0]   wait_limit;
    logic [7:0]    next_byte;
    logic          qtick;
    logic          unit_end;
    logic          sample;
    logic          stop_end;
    logic          rd_txn;
    logic [2:0]    last_wr_idx;
    logic          go;
    logic          scl_bit_low;

    assign sda_s       = sda_sync[1];
    assign qtick       = (qcnt == QLAST);
    assign unit_end    = qtick && (phase == 2'd3);
    assign sample      = qtick && (phase == 2'd1);
    assign stop_end    = (tstate == T_STOP) && unit_end;
    assign rd_txn      = (sstate == Q_READ);
    assign last_wr_idx = (sstate == Q_CONV) ? 3'd1 : 3'd2;
    assign scl_bit_low = (phase == 2'd0) || (phase == 2'd3);
    assign busy        = (tstate != T_IDLE);
    assign go          = !issued && (tstate == T_IDLE) &&
                         ((sstate == Q_INIT1) || (sstate == Q_INIT2) ||
                          (sstate == Q_CONV)  || (sstate == Q_READ));

    // Two-flop synchronizer for the asynchronous SDA line
    always_ff @(posedge clock) begin
        if (reset) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    // Data byte that follows byte_idx in the current write transfer
    always_comb begin
        next_byte = 8'h00;
        case (sstate)
            Q_INIT1: next_byte = (byte_idx == 3'd0) ? 8'hF0 : 8'h55;
            Q_INIT2: next_byte = (byte_idx == 3'd0) ? 8'hFB : 8'h00;
            default: next_byte = 8'h00;
        endcase
    end

    // Length of the current idle delay
    always_comb begin
        wait_limit = RETRY_CYC;
        case (sstate)
            Q_CONVW: wait_limit = CONV_CYC;
            Q_POLLW: wait_limit = POLL_CYC;
            default: wait_limit = RETRY_CYC;
        endcase
    end

    // Line drive decode from transaction state and quarter-bit phase
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (tstate)
            T_START: begin
                scl_oe = (phase == 2'd3);
                sda_oe = (phase >= 2'd2);
            end
            T_TXBYTE: begin
                scl_oe = scl_bit_low;
                sda_oe = ~tx_sh[7];
            end
            T_RXACK, T_RXBYTE: begin
                scl_oe = scl_bit_low;
            end
            T_TXACK: begin
                scl_oe = scl_bit_low;
                sda_oe = (byte_idx != 3'd5);
            end
            T_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase <= 2'd1);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // Bit engine: quarter timing, shifting, ACK handling and byte sequencing within one transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            tstate    <= T_IDLE;
            phase     <= 2'd0;
            qcnt      <= '0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 3'd0;
            tx_sh     <= 8'h00;
            rx_buf    <= 48'h0;
            nack_seen <= 1'b0;
        end else if (tstate == T_IDLE) begin
            qcnt  <= '0;
            phase <= 2'd0;
            if (go) begin
                tstate    <= T_START;
                tx_sh     <= {DEV_ADDR, rd_txn};
                byte_idx  <= 3'd0;
                bit_cnt   <= 3'd7;
                nack_seen <= 1'b0;
            end
        end else begin
            qcnt <= qtick ? '0 : qcnt + 1'b1;
            if (qtick) begin
                phase <= phase + 2'd1;
            end
            if (sample && (tstate == T_RXACK)) begin
                nack_seen <= sda_s;
            end
            if (sample && (tstate == T_RXBYTE)) begin
                rx_buf <= {rx_buf[46:0], sda_s};
            end
            if (unit_end) begin
                case (tstate)
                    T_START: begin
                        tstate  <= T_TXBYTE;
                        bit_cnt <= 3'd7;
                    end
                    T_TXBYTE: begin
                        if (bit_cnt == 3'd0) begin
                            tstate <= T_RXACK;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                        end
                    end
                    T_RXACK: begin
                        if (nack_seen) begin
                            tstate <= T_STOP;
                        end else if (rd_txn) begin
                            tstate  <= T_RXBYTE;
                            bit_cnt <= 3'd7;
                        end else if (byte_idx == last_wr_idx) begin
                            tstate <= T_STOP;
                        end else begin
                            tstate   <= T_TXBYTE;
                            tx_sh    <= next_byte;
                            byte_idx <= byte_idx + 3'd1;
                            bit_cnt  <= 3'd7;
                        end
                    end
                    T_RXBYTE: begin
                        if (bit_cnt == 3'd0) begin
                            tstate <= T_TXACK;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    T_TXACK: begin
                        if (byte_idx == 3'd5) begin
                            tstate <= T_STOP;
                        end else begin
                            tstate   <= T_RXBYTE;
                            byte_idx <= byte_idx + 3'd1;
                            bit_cnt  <= 3'd7;
                        end
                    end
                    default: begin
                        tstate <= T_IDLE;
                    end
                endcase
            end
        end
    end

    // Sequencer: init writes, conversion trigger, sample read, delays, NACK back-off and commit
    always_ff @(posedge clock) begin
        if (reset) begin
            sstate     <= Q_INIT1;
            issued     <= 1'b0;
            wcnt       <= 32'd0;
            wii_data   <= 48'h0;
            data_valid <= 1'b0;
            ack_error  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (go) begin
                issued <= 1'b1;
            end
            if ((sstate == Q_CONVW) || (sstate == Q_POLLW) || (sstate == Q_RETRYW)) begin
                if (wcnt == wait_limit - 32'd1) begin
                    wcnt <= 32'd0;
                    if (sstate == Q_CONVW) begin
                        sstate <= Q_READ;
                    end else if (sstate == Q_POLLW) begin
                        sstate <= Q_CONV;
                    end else begin
                        sstate <= Q_INIT1;
                    end
                end else begin
                    wcnt <= wcnt + 32'd1;
                end
            end else if (stop_end) begin
                issued <= 1'b0;
                wcnt   <= 32'd0;
                if (nack_seen) begin
                    ack_error <= 1'b1;
                    sstate    <= Q_RETRYW;
                end else if (sstate == Q_INIT1) begin
                    sstate <= Q_INIT2;
                end else if (sstate == Q_INIT2) begin
                    sstate <= Q_CONV;
                end else if (sstate == Q_CONV) begin
                    sstate <= Q_CONVW;
                end else begin
                    wii_data   <= rx_buf;
                    data_valid <= 1'b1;
                    ack_error  <= 1'b0;
                    sstate     <= Q_POLLW;
                end
            end
        end
    end
endmodule

// File: tb/tb_wii_nunchuk_reader.sv
// tb/tb_wii_nunchuk_reader.sv - directed bench for wii_nunchuk_reader with a Nunchuk slave model
module tb_wii_nunchuk_reader;
    localparam int ST = 256;
    localparam int SP = 512;
    localparam int MA = 768;

    logic        clock = 1'b0;
    logic        reset;
    logic        sda_in;
    logic        scl_oe;
    logic        sda_oe;
    logic [47:0] wii_data;
    logic        data_valid;
    logic        busy;
    logic        ack_error;
    logic        scl_line;
    logic        slave_pull = 1'b0;
    logic        slave_rst;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;

    int slog[$];
    logic [7:0] rd_bytes [6];
    int nack_req = 0;
    int nack_used = 0;

    int s_mode = 0;
    int s_bitn = 0;
    int s_byte = 0;
    int s_idx = 0;
    int s_rdcnt = 0;
    logic s_read = 1'b0;
    logic s_mack = 1'b1;
    logic [7:0] s_sh = 8'h00;
    logic s_pscl = 1'b1;
    logic s_psda = 1'b1;

    int cyc = 0;
    int dv_count = 0;
    int dv_run = 0;
    int dv_maxrun = 0;
    int last_rise = -1000;
    int scl_bad = 0;
    logic m_pscl = 1'b1;

    always #5 clock = ~clock;

    assign scl_line = ~scl_oe;
    assign sda_in = ~(sda_oe | slave_pull);

    wii_nunchuk_reader #(
        .CLK_HZ   (100_000_000),
        .I2C_HZ   (6_250_000),
        .DEV_ADDR (7'h52),
        .CONV_CYC (50),
        .POLL_CYC (200),
        .RETRY_CYC(300)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sda_in    (sda_in),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .wii_data  (wii_data),
        .data_valid(data_valid),
        .busy      (busy),
        .ack_error (ack_error)
    );

    // Nunchuk slave: logs START/STOP, written bytes and master ACK bits; serves rd_bytes on reads
    always @(negedge clock) begin
        if (slave_rst) begin
            s_mode = 0;
            slave_pull = 1'b0;
            s_pscl = 1'b1;
            s_psda = 1'b1;
        end else begin
            if (s_pscl && scl_line && s_psda && !sda_in) begin
                slog.push_back(ST);
                s_mode = 1; s_bitn = 0; s_byte = 0; s_read = 1'b0; s_rdcnt = 0;
                slave_pull = 1'b0;
            end else if (s_pscl && scl_line && !s_psda && sda_in) begin
                slog.push_back(SP);
                s_mode = 0;
                slave_pull = 1'b0;
            end else if (!s_pscl && scl_line) begin
                case (s_mode)
                    1: begin s_sh = {s_sh[6:0], sda_in}; s_bitn++; end
                    3: s_bitn++;
                    4: begin s_mack = sda_in; slog.push_back(MA + int'(sda_in)); s_rdcnt++; end
                    default: ;
                endcase
            end else if (s_pscl && !scl_line) begin
                case (s_mode)
                    1: if (s_bitn == 8) begin
                        slog.push_back(int'(s_sh));
                        if (s_byte == 0) s_read = s_sh[0];
                        if (s_byte == 0 && nack_used != nack_req) begin
                            nack_used++;
                            s_mode = 5;
                            slave_pull = 1'b0;
                        end else begin
                            s_mode = 2;
                            slave_pull = 1'b1;
                        end
                        s_byte++;
                    end
                    2: begin
                        s_bitn = 0;
                        if (s_read) begin
                            s_mode = 3; s_idx = 0;
                            slave_pull = !rd_bytes[0][7];
                        end else begin
                            s_mode = 1;
                            slave_pull = 1'b0;
                        end
                    end
                    3: if (s_bitn == 8) begin
                        s_mode = 4;
                        slave_pull = 1'b0;
                    end else begin
                        slave_pull = !rd_bytes[s_idx][7 - s_bitn];
                    end
                    4: if (!s_mack && s_idx < 5) begin
                        s_idx++; s_bitn = 0; s_mode = 3;
                        slave_pull = !rd_bytes[s_idx][7];
                    end else begin
                        s_mode = 5;
                        slave_pull = 1'b0;
                    end
                    default: ;
                endcase
            end
            s_pscl = scl_line;
            s_psda = sda_in;
        end
    end

    // Pulse-width and SCL rise-spacing monitor
    always @(negedge clock) begin
        cyc++;
        if (data_valid === 1'b1) begin
            dv_count++;
            dv_run++;
            if (dv_run > dv_maxrun) dv_maxrun = dv_run;
        end else begin
            dv_run = 0;
        end
        if (scl_line === 1'b1 && m_pscl === 1'b0) begin
            if ((cyc - last_rise) <= 24 && (cyc - last_rise) != 16) scl_bad++;
            last_rise = cyc;
        end
        m_pscl = scl_line;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        tcnt++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_log(input string tag, input int base, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            int got;
            got = (base + i < slog.size()) ? slog[base + i] : -1;
            check($sformatf("%s[%0d]", tag, i), 64'(got), 64'(exp[i]));
        end
    endtask

    task automatic wait_dv(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (data_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int e[$];
        int t1;
        int mark;
        int n;
        int dvc;
        bit seen;

        reset = 1'b1;
        slave_rst = 1'b1;
        rd_bytes = '{8'h80, 8'h7F, 8'h12, 8'h34, 8'h56, 8'hFD};
        repeat (3) tick();
        check("rst_scl_oe", 64'(scl_oe), 64'd0);
        check("rst_sda_oe", 64'(sda_oe), 64'd0);
        check("rst_wii_data", 64'(wii_data), 64'd0);
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack_error", 64'(ack_error), 64'd0);

        reset = 1'b0;
        slave_rst = 1'b0;
        wait_dv("first_read_seen", 4000);
        t1 = tcnt;
        check("first_read_data", 64'(wii_data), 64'h807F123456FD);
        check("first_read_ack_error", 64'(ack_error), 64'd0);
        check("first_read_busy", 64'(busy), 64'd0);
        tick();
        check("dv_one_cycle", 64'(data_valid), 64'd0);
        e = '{ST, 8'hA4, 8'hF0, 8'h55, SP,
              ST, 8'hA4, 8'hFB, 8'h00, SP,
              ST, 8'hA4, 8'h00, SP,
              ST, 8'hA5, MA, MA, MA, MA, MA, MA + 1, SP};
        check_log("bringup_log", 0, e);

        // Poll period: READ commit to next commit = POLL 200 + CONV 320 + CONV_CYC 50 + READ 1040 + go cycles
        mark = slog.size();
        wait_dv("second_read_seen", 2500);
        check_range("poll_period", tcnt - t1, 1610, 1614);
        check("second_read_data", 64'(wii_data), 64'h807F123456FD);
        e = '{ST, 8'hA4, 8'h00, SP, ST, 8'hA5};
        check_log("poll_log", mark, e);

        // Slave NACKs the address of the next transfer (CONV)
        nack_req = 1;
        mark = slog.size();
        rd_bytes = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h10};
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ack_error === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("nack_ack_error", 64'(seen), 64'd1);
        check("nack_wii_hold", 64'(wii_data), 64'h807F123456FD);
        check("nack_busy_done", 64'(busy), 64'd0);
        e = '{ST, 8'hA4, SP};
        check_log("nack_log", mark, e);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (busy === 1'b1) break;
        end
        check_range("retry_gap", n, 300, 304);
        check("retry_ack_error_held", 64'(ack_error), 64'd1);
        wait_dv("recover_read_seen", 4000);
        check("recover_ack_error", 64'(ack_error), 64'd0);
        check("recover_data", 64'(wii_data), 64'h00FFA55A0110);
        e = '{ST, 8'hA4, 8'hF0, 8'h55, SP, ST, 8'hA4, 8'hFB, 8'h00, SP};
        check_log("reinit_log", mark + 3, e);
        check("dv_max_width", 64'(dv_maxrun), 64'd1);
        check("scl_spacing", 64'(scl_bad), 64'd0);

        // Reset in the middle of a READ, after byte 3 has been acknowledged
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (s_rdcnt == 4 && busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("midread_reached", 64'(seen), 64'd1);
        reset = 1'b1;
        slave_rst = 1'b1;
        dvc = dv_count;
        tick();
        check("midrst_scl_oe", 64'(scl_oe), 64'd0);
        check("midrst_sda_oe", 64'(sda_oe), 64'd0);
        check("midrst_wii_data", 64'(wii_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        slave_rst = 1'b0;
        mark = slog.size();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (slog.size() >= mark + 5 && busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("restart_done", 64'(seen), 64'd1);
        e = '{ST, 8'hA4, 8'hF0, 8'h55, SP};
        check_log("restart_log", mark, e);
        check("restart_no_dv", 64'(dv_count), 64'(dvc));
        check("restart_wii_zero", 64'(wii_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
